// File: rtl/demux16_tdm.sv
// demux16_tdm: receive end of the 16-to-1 slot-select path.
// Collects one serial bit per accepted beat into a shadow word, indexed by the
// slot counter, and publishes the word on dout once slot 15 arrives. An early
// start-of-frame restarts collection and flags the abandoned frame.
module demux16_tdm #(
    parameter int SLOTS = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [SLOTS-1:0] dout,
    output logic             frame_valid,
    output logic             frame_err,
    output logic             busy,
    output logic [SEL_W-1:0] slot
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] SLOT_ZERO = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] SLOT_ONE  = SLOT_ZERO + 1'b1;
    localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(SLOTS - 1);

    state_t           state_r;
    logic [SEL_W-1:0] slot_r;
    logic [SLOTS-1:0] shadow_r;
    logic [SLOTS-1:0] dout_r;
    logic             frame_valid_r;
    logic             frame_err_r;
    logic             busy_r;

    // Frame collection FSM: shadow/slot bookkeeping and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            slot_r        <= SLOT_ZERO;
            shadow_r      <= {SLOTS{1'b0}};
            dout_r        <= {SLOTS{1'b0}};
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-raised below.
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            if (din_valid) begin
                case (state_r)
                    IDLE: begin
                        // Beats without sof while idle are line noise and are dropped.
                        if (sof) begin
                            shadow_r[0] <= din;
                            slot_r      <= SLOT_ONE;
                            state_r     <= RECV;
                            busy_r      <= 1'b1;
                        end else begin
                            state_r     <= IDLE;
                        end
                    end
                    RECV: begin
                        if (sof) begin
                            // Resync: abandon the partial frame, dout keeps the last good word.
                            frame_err_r <= 1'b1;
                            shadow_r[0] <= din;
                            slot_r      <= SLOT_ONE;
                            state_r     <= RECV;
                        end else begin
                            shadow_r[slot_r] <= din;
                            if (slot_r == SLOT_LAST) begin
                                dout_r        <= {din, shadow_r[SLOTS-2:0]};
                                frame_valid_r <= 1'b1;
                                slot_r        <= SLOT_ZERO;
                                state_r       <= IDLE;
                                busy_r        <= 1'b0;
                            end else begin
                                slot_r        <= slot_r + SLOT_ONE;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        slot_r  <= SLOT_ZERO;
                        busy_r  <= 1'b0;
                    end
                endcase
            end else begin
                // No accepted beat: gaps of any length hold all frame state.
                state_r <= state_r;
            end
        end
    end

    assign dout        = dout_r;
    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;
    assign busy        = busy_r;
    assign slot        = slot_r;

endmodule
